alu_arbiter: RTL and testbench

//  Shares the single 16-bit signed ALU between two requesters.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one signed ALU between two requesters: port 0 is the execute stage
//   and port 1 is the address/PC-increment path. Requests are arbitrated
//   round-robin. Only one operation is in flight at a time. The ALU is driven
//   from registers, and its result is captured and returned on the granted
//   port's response channel.
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   mN_req_valid/ready          request handshake (ready is combinational)
//   mN_req_ctrl/a/b             opcode and operands of the request
//   mN_rsp_valid/ready/data     response handshake and result
//   alu_ctrl, op_a, op_b        registered ALU inputs
//   alu_result                  ALU output, captured ALU_LAT cycles after issue
//   busy                        high whenever the arbiter is not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready offered to the winner only
// EXEC  | ALU inputs held; count down ALU_LAT-1..0, then capture result
// RESP  | rsp_valid on the granted port until that port's rsp_ready

module alu_arbiter #(
   parameter int WIDTH   = 16,
   parameter int CTRL_W  = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [CTRL_W-1:0] m0_req_ctrl,
   input  logic [WIDTH-1:0]  m0_req_a,
   input  logic [WIDTH-1:0]  m0_req_b,
   output logic              m0_rsp_valid,
   input  logic              m0_rsp_ready,
   output logic [WIDTH-1:0]  m0_rsp_data,

   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [CTRL_W-1:0] m1_req_ctrl,
   input  logic [WIDTH-1:0]  m1_req_a,
   input  logic [WIDTH-1:0]  m1_req_b,
   output logic              m1_rsp_valid,
   input  logic              m1_rsp_ready,
   output logic [WIDTH-1:0]  m1_rsp_data,

   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [WIDTH-1:0]  op_a,
   output logic [WIDTH-1:0]  op_b,
   input  logic [WIDTH-1:0]  alu_result,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t           state;
   logic             rr_ptr;
   logic             grant;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] rsp_data;
   logic [1:0]       rsp_valid;
   logic             winner;
   logic             accept;
   logic             gnt_rsp_ready;

   // A lone requester always wins; rr_ptr only breaks ties.
   always_comb begin
      if (m0_req_valid && m1_req_valid) begin
         winner = rr_ptr;
      end else begin
         winner = m1_req_valid;
      end
   end

   assign m0_req_ready  = (state == IDLE) && m0_req_valid && !winner;
   assign m1_req_ready  = (state == IDLE) && m1_req_valid && winner;
   assign accept        = m0_req_ready || m1_req_ready;
   assign gnt_rsp_ready = grant ? m1_rsp_ready : m0_rsp_ready;

   assign m0_rsp_valid  = rsp_valid[0];
   assign m1_rsp_valid  = rsp_valid[1];
   // Result is only visible on the port that owns it.
   assign m0_rsp_data   = grant ? '0 : rsp_data;
   assign m1_rsp_data   = grant ? rsp_data : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         grant     <= 1'b0;
         cnt       <= '0;
         rsp_data  <= '0;
         rsp_valid <= '0;
         alu_ctrl  <= '0;
         op_a      <= '0;
         op_b      <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_ctrl <= winner ? m1_req_ctrl : m0_req_ctrl;
                  op_a     <= winner ? m1_req_a    : m0_req_a;
                  op_b     <= winner ? m1_req_b    : m0_req_b;
                  grant    <= winner;
                  rr_ptr   <= ~winner;
                  cnt      <= CNT_INIT;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  rsp_data  <= alu_result;
                  rsp_valid <= grant ? 2'b10 : 2'b01;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (gnt_rsp_ready) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int LAT = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
   logic [3:0]  m0_req_ctrl;
   logic [15:0] m0_req_a, m0_req_b, m0_rsp_data;
   logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
   logic [3:0]  m1_req_ctrl;
   logic [15:0] m1_req_a, m1_req_b, m1_rsp_data;
   logic [3:0]  alu_ctrl;
   logic [15:0] op_a, op_b, alu_result;
   logic        busy;

   logic        t_reset;
   logic        t_m0_req_valid, t_m0_req_ready, t_m0_rsp_valid, t_m0_rsp_ready;
   logic [3:0]  t_m0_req_ctrl;
   logic [15:0] t_m0_req_a, t_m0_req_b, t_m0_rsp_data;
   logic        t_m1_req_valid, t_m1_req_ready, t_m1_rsp_valid, t_m1_rsp_ready;
   logic [3:0]  t_m1_req_ctrl;
   logic [15:0] t_m1_req_a, t_m1_req_b, t_m1_rsp_data;
   logic [3:0]  t_alu_ctrl;
   logic [15:0] t_op_a, t_op_b, t_alu_result;
   logic        t_busy;
   logic [15:0] t_d1, t_d2;

   function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [15:0] a,
                                          input logic [15:0] b);
      case (c)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   // ALU behind the LAT=1 arbiter: purely combinational
   always_comb alu_result = alu_fn(alu_ctrl, op_a, op_b);

   // ALU behind the LAT=3 arbiter: two register stages after the logic
   always @(posedge clk) begin
      t_d1 <= alu_fn(t_alu_ctrl, t_op_a, t_op_b);
      t_d2 <= t_d1;
   end
   assign t_alu_result = t_d2;

   alu_arbiter #(.WIDTH(16), .CTRL_W(4), .ALU_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_ctrl(m0_req_ctrl),
      .m0_req_a(m0_req_a), .m0_req_b(m0_req_b), .m0_rsp_valid(m0_rsp_valid),
      .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(m0_rsp_data),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_ctrl(m1_req_ctrl),
      .m1_req_a(m1_req_a), .m1_req_b(m1_req_b), .m1_rsp_valid(m1_rsp_valid),
      .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(m1_rsp_data),
      .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .alu_result(alu_result), .busy(busy)
   );

   alu_arbiter #(.WIDTH(16), .CTRL_W(4), .ALU_LAT(3)) dut3 (
      .clk(clk), .reset(t_reset),
      .m0_req_valid(t_m0_req_valid), .m0_req_ready(t_m0_req_ready), .m0_req_ctrl(t_m0_req_ctrl),
      .m0_req_a(t_m0_req_a), .m0_req_b(t_m0_req_b), .m0_rsp_valid(t_m0_rsp_valid),
      .m0_rsp_ready(t_m0_rsp_ready), .m0_rsp_data(t_m0_rsp_data),
      .m1_req_valid(t_m1_req_valid), .m1_req_ready(t_m1_req_ready), .m1_req_ctrl(t_m1_req_ctrl),
      .m1_req_a(t_m1_req_a), .m1_req_b(t_m1_req_b), .m1_rsp_valid(t_m1_rsp_valid),
      .m1_rsp_ready(t_m1_rsp_ready), .m1_rsp_data(t_m1_rsp_data),
      .alu_ctrl(t_alu_ctrl), .op_a(t_op_a), .op_b(t_op_b), .alu_result(t_alu_result),
      .busy(t_busy)
   );

   int total  = 0;
   int passed = 0;
   int fails  = 0;
   int cyc    = 0;

   // requester side
   logic        req_v[2];
   logic [3:0]  req_c[2];
   logic [15:0] req_a[2], req_b[2];
   logic        rsp_r[2];
   int          gen_pct[2], rdy_pct[2];
   logic        rst_drv;

   // transaction-level reference model
   bit          out_act;
   int          out_port, acc_cyc, free_at, fav;
   logic [15:0] out_data;
   logic [3:0]  last_c;
   logic [15:0] last_a, last_b;
   int          acc_log[$];
   int          acc_cyc_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      out_act = 0; fav = 0; free_at = 0;
      last_c = '0; last_a = '0; last_b = '0;
   endtask

   task automatic check();
      logic [1:0] er, ev;
      if (reset) begin
         chk("rst_m0_req_ready", m0_req_ready, 0);
         chk("rst_m1_req_ready", m1_req_ready, 0);
         chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
         chk("rst_m1_rsp_valid", m1_rsp_valid, 0);
         chk("rst_m0_rsp_data", m0_rsp_data, 0);
         chk("rst_m1_rsp_data", m1_rsp_data, 0);
         chk("rst_alu_ctrl", alu_ctrl, 0);
         chk("rst_op_a", op_a, 0);
         chk("rst_op_b", op_b, 0);
         chk("rst_busy", busy, 0);
         model_reset();
         return;
      end
      er = '0;
      if (!out_act && cyc >= free_at) begin
         if (req_v[0] && req_v[1]) er[fav] = 1'b1;
         else if (req_v[0])        er[0]   = 1'b1;
         else if (req_v[1])        er[1]   = 1'b1;
      end
      ev = '0;
      if (out_act && cyc >= acc_cyc + 1 + LAT) ev[out_port] = 1'b1;
      chk("m0_req_ready", m0_req_ready, er[0]);
      chk("m1_req_ready", m1_req_ready, er[1]);
      chk("m0_rsp_valid", m0_rsp_valid, ev[0]);
      chk("m1_rsp_valid", m1_rsp_valid, ev[1]);
      chk("busy", busy, out_act);
      chk("alu_ctrl", alu_ctrl, last_c);
      chk("op_a", op_a, last_a);
      chk("op_b", op_b, last_b);
      if (ev[0]) chk("m0_rsp_data", m0_rsp_data, out_data);
      if (ev[1]) chk("m1_rsp_data", m1_rsp_data, out_data);
      for (int p = 0; p < 2; p++) begin
         if (er[p]) begin
            out_act  = 1;
            out_port = p;
            acc_cyc  = cyc;
            out_data = alu_fn(req_c[p], req_a[p], req_b[p]);
            last_c   = req_c[p];
            last_a   = req_a[p];
            last_b   = req_b[p];
            fav      = 1 - p;
            req_v[p] = 1'b0;
            acc_log.push_back(p);
            acc_cyc_log.push_back(cyc);
         end
         if (ev[p] && rsp_r[p]) begin
            out_act = 0;
            free_at = cyc + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
         if (!req_v[p] && ($urandom_range(99) < gen_pct[p])) begin
            req_v[p] = 1'b1;
            req_c[p] = 4'($urandom_range(0, 7));
            req_a[p] = 16'($urandom);
            req_b[p] = 16'($urandom);
         end
         rsp_r[p] = ($urandom_range(99) < rdy_pct[p]);
      end
      reset        = rst_drv;
      m0_req_valid = req_v[0]; m0_req_ctrl = req_c[0]; m0_req_a = req_a[0]; m0_req_b = req_b[0];
      m1_req_valid = req_v[1]; m1_req_ctrl = req_c[1]; m1_req_a = req_a[1]; m1_req_b = req_b[1];
      m0_rsp_ready = rsp_r[0];
      m1_rsp_ready = rsp_r[1];
      @(negedge clk);
      check();
   endtask

   task automatic issue(input int p, input logic [3:0] c, input logic [15:0] a,
                        input logic [15:0] b);
      req_v[p] = 1'b1; req_c[p] = c; req_a[p] = a; req_b[p] = b;
   endtask

   task automatic drain();
      int n;
      n = 0;
      gen_pct[0] = 0; gen_pct[1] = 0;
      rdy_pct[0] = 100; rdy_pct[1] = 100;
      while ((out_act || req_v[0] || req_v[1]) && n < 60) begin
         tick();
         n++;
      end
      chk("drain_bound", 32'(out_act || req_v[0] || req_v[1]), 0);
   endtask

   initial begin
      logic [3:0]  c;
      logic [15:0] a, b;
      int          n;

      for (int p = 0; p < 2; p++) begin
         req_v[p] = 0; req_c[p] = '0; req_a[p] = '0; req_b[p] = '0; rsp_r[p] = 0;
         gen_pct[p] = 0; rdy_pct[p] = 100;
      end
      model_reset();
      rst_drv = 1'b1; reset = 1'b1;
      m0_req_valid = 0; m0_req_ctrl = '0; m0_req_a = '0; m0_req_b = '0; m0_rsp_ready = 0;
      m1_req_valid = 0; m1_req_ctrl = '0; m1_req_a = '0; m1_req_b = '0; m1_rsp_ready = 0;
      t_reset = 1'b1;
      t_m0_req_valid = 0; t_m0_req_ctrl = '0; t_m0_req_a = '0; t_m0_req_b = '0; t_m0_rsp_ready = 1;
      t_m1_req_valid = 0; t_m1_req_ctrl = '0; t_m1_req_a = '0; t_m1_req_b = '0; t_m1_rsp_ready = 0;

      // reset state
      tick();
      tick();
      rst_drv = 1'b0;

      // single op on port 0: ADD 5 + -3
      issue(0, 4'd0, 16'sd5, -16'sd3);
      tick();
      chk("s1_accept_T", m0_req_ready, 1);
      chk("s1_m1_ready_T", m1_req_ready, 0);
      tick();
      chk("s1_valid_T1", m0_rsp_valid, 0);
      tick();
      chk("s1_valid_T2", m0_rsp_valid, 1);
      chk("s1_data", m0_rsp_data, 16'd2);
      chk("s1_m1_valid", m1_rsp_valid, 0);
      chk("s1_m1_data", m1_rsp_data, 0);
      tick();
      chk("s1_valid_drop", m0_rsp_valid, 0);

      // contention from reset: both always valid -> alternating grants
      rst_drv = 1'b1;
      tick();
      rst_drv = 1'b0;
      acc_log.delete();
      gen_pct[0] = 100; gen_pct[1] = 100;
      n = 0;
      while (acc_log.size() < 4 && n < 40) begin tick(); n++; end
      chk("s2_accept_bound", 32'(acc_log.size() >= 4), 1);
      if (acc_log.size() >= 4) begin
         chk("s2_grant0", acc_log[0], 0);
         chk("s2_grant1", acc_log[1], 1);
         chk("s2_grant2", acc_log[2], 0);
         chk("s2_grant3", acc_log[3], 1);
      end
      drain();

      // backpressure on port 1 while port 0 keeps requesting
      rdy_pct[1] = 0;
      issue(1, 4'd1, 16'($urandom), 16'($urandom));
      gen_pct[0] = 100;
      n = 0;
      while (!(out_act && out_port == 1 && cyc >= acc_cyc + 1 + LAT) && n < 30) begin
         tick(); n++;
      end
      chk("s3_resp_bound", 32'(n < 30), 1);
      for (int k = 0; k < 5; k++) begin
         chk("s3_m1_rsp_valid", m1_rsp_valid, 1);
         chk("s3_m1_rsp_data", m1_rsp_data, out_data);
         chk("s3_m0_req_ready", m0_req_ready, 0);
         chk("s3_busy", busy, 1);
         if (k < 4) tick();
      end
      drain();

      // randomized traffic
      gen_pct[0] = 50; gen_pct[1] = 50;
      rdy_pct[0] = 60; rdy_pct[1] = 60;
      for (int k = 0; k < 300; k++) tick();
      drain();

      // reset one cycle after accept aborts the op and restores rr_ptr
      issue(0, 4'd4, 16'($urandom), 16'($urandom));
      tick();
      chk("s4_accept", m0_req_ready, 1);
      rst_drv = 1'b1;
      tick();
      chk("s4_busy", busy, 0);
      chk("s4_m0_rsp_valid", m0_rsp_valid, 0);
      rst_drv = 1'b0;
      issue(0, 4'd2, 16'($urandom), 16'($urandom));
      issue(1, 4'd3, 16'($urandom), 16'($urandom));
      tick();
      chk("s4_rr_m0_ready", m0_req_ready, 1);
      chk("s4_rr_m1_ready", m1_req_ready, 0);
      drain();

      // lone requester on port 1, continuous valid
      acc_cyc_log.delete();
      gen_pct[1] = 100; rdy_pct[1] = 100;
      n = 0;
      while (acc_cyc_log.size() < 5 && n < 40) begin tick(); n++; end
      chk("s6_accept_bound", 32'(acc_cyc_log.size() >= 5), 1);
      for (int k = 1; k < acc_cyc_log.size(); k++)
         chk("s6_interval", 32'(acc_cyc_log[k] - acc_cyc_log[k-1]), 3);
      drain();

      // ALU_LAT=3 instance: accept at T, rsp_valid at T+4
      t_reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin c = 4'd1; a = 16'd100;  b = 16'd7;   end
         else        begin c = 4'd0; a = 16'sd5;   b = -16'sd3; end
         t_m0_req_valid = 1'b1; t_m0_req_ctrl = c; t_m0_req_a = a; t_m0_req_b = b;
         #1;
         chk("s5_accept_T", t_m0_req_ready, 1);
         tick();
         t_m0_req_valid = 1'b0;
         for (int j = 1; j <= 3; j++) begin
            chk("s5_rsp_valid_early", t_m0_rsp_valid, 0);
            chk("s5_alu_ctrl_hold", t_alu_ctrl, c);
            chk("s5_op_a_hold", t_op_a, a);
            chk("s5_op_b_hold", t_op_b, b);
            tick();
         end
         chk("s5_rsp_valid_T4", t_m0_rsp_valid, 1);
         chk("s5_rsp_data", t_m0_rsp_data, alu_fn(c, a, b));
         chk("s5_m1_rsp_valid", t_m1_rsp_valid, 0);
         tick();
         chk("s5_rsp_valid_drop", t_m0_rsp_valid, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
